// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 integer register file.
package msrv32_pkg;

    localparam int XLEN_C = 32;
    localparam int NREG_C = 32;
    localparam int AW_C   = 5;

    typedef logic [AW_C-1:0]   reg_addr_t;
    typedef logic [XLEN_C-1:0] xlen_t;

    localparam reg_addr_t X0_ADDR = '0;

endpackage

// File: rtl/msrv32_rf_bypass_mux.sv
// Per-read-port match against all write ports; the highest-index enabled match wins.
module msrv32_rf_bypass_mux
    import msrv32_pkg::*;
#(
    parameter int XLEN   = XLEN_C,
    parameter int AW     = AW_C,
    parameter int NUM_WR = 1
) (
    input  logic [AW-1:0]          rs_addr,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   rd_addr,
    input  logic [NUM_WR*XLEN-1:0] rd_data,
    output logic [XLEN-1:0]        data,
    output logic                   hit
);

    // NOTE: defaults assigned first so every path writes both outputs; no latch is inferred.
    always_comb begin
        data = '0;
        hit  = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && rs_addr != AW'(X0_ADDR) && rd_addr[k*AW +: AW] == rs_addr) begin
                hit  = 1'b1;
                data = rd_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/msrv32_regfile_mp.sv
// Multi-port RV32I register file with x0 hardwired to zero, optional write bypass and a busy scoreboard.
module msrv32_regfile_mp
    import msrv32_pkg::*;
#(
    parameter int XLEN   = XLEN_C,
    parameter int NREG   = NREG_C,
    parameter int AW     = AW_C,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [NUM_RD*AW-1:0]   rs_addr_in,
    output logic [NUM_RD*XLEN-1:0] rs_out,
    output logic [NUM_RD-1:0]      rs_busy_out,
    input  logic [NUM_WR-1:0]      wr_en_in,
    input  logic [NUM_WR*AW-1:0]   rd_addr_in,
    input  logic [NUM_WR*XLEN-1:0] rd_in,
    input  logic                   issue_en_in,
    input  logic [AW-1:0]          issue_addr_in,
    output logic                   any_busy_out
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // NOTE: the array is reset deliberately because reset must make every register read 0.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Later iterations overwrite earlier ones, so the highest-index port wins.
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_in[k] && rd_addr_in[k*AW +: AW] != AW'(X0_ADDR)) begin
                    regs[rd_addr_in[k*AW +: AW]] <= rd_in[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Writeback clears first, then issue sets, so a new producer supersedes the old one.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en_in[k]) begin
                busy_nxt[rd_addr_in[k*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en_in) begin
            busy_nxt[issue_addr_in] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign any_busy_out = |busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] byp_data;
        logic            byp_hit;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rs_addr_in[i*AW +: AW];

        msrv32_rf_bypass_mux #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NUM_WR (NUM_WR)
        ) u_byp (
            .rs_addr (addr),
            .wr_en   (wr_en_in),
            .rd_addr (rd_addr_in),
            .rd_data (rd_in),
            .data    (byp_data),
            .hit     (byp_hit)
        );

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (BYPASS != 0 && byp_hit) begin
                data = byp_data;
                bsy  = issue_en_in && (issue_addr_in == addr);
            end
            if (reset_in || addr == AW'(X0_ADDR)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rs_out[i*XLEN +: XLEN] = data;
        assign rs_busy_out[i]         = bsy;
    end

endmodule

// File: tb/tb_msrv32_regfile_mp.sv
// Scoreboard bench: a BYPASS=0/NUM_WR=1 instance and a BYPASS=1/NUM_WR=2 instance share reads and issue.
module tb_msrv32_regfile_mp;

    logic        clk;
    logic        clk_run;
    logic        reset;
    logic [9:0]  rs_addr;
    logic        issue_en;
    logic [4:0]  issue_addr;

    logic [0:0]  wr_en0;
    logic [4:0]  rd_addr0;
    logic [31:0] rd0;
    logic [63:0] rs0;
    logic [1:0]  busy0;
    logic        any0;

    logic [1:0]  wr_en1;
    logic [9:0]  rd_addr1;
    logic [63:0] rd1;
    logic [63:0] rs1;
    logic [1:0]  busy1;
    logic        any1;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic        any;
        string       name;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    msrv32_regfile_mp #(.NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut0 (
        .clk_in        (clk),
        .reset_in      (reset),
        .rs_addr_in    (rs_addr),
        .rs_out        (rs0),
        .rs_busy_out   (busy0),
        .wr_en_in      (wr_en0),
        .rd_addr_in    (rd_addr0),
        .rd_in         (rd0),
        .issue_en_in   (issue_en),
        .issue_addr_in (issue_addr),
        .any_busy_out  (any0)
    );

    msrv32_regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut1 (
        .clk_in        (clk),
        .reset_in      (reset),
        .rs_addr_in    (rs_addr),
        .rs_out        (rs1),
        .rs_busy_out   (busy1),
        .wr_en_in      (wr_en1),
        .rd_addr_in    (rd_addr1),
        .rd_in         (rd1),
        .issue_en_in   (issue_en),
        .issue_addr_in (issue_addr),
        .any_busy_out  (any1)
    );

    always #5 clk = clk_run ? ~clk : clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops every queued expectation whenever the stimulus marks a sample point.
    always begin
        @(sample_ev);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a_data;
            logic        a_busy;
            logic        a_any;
            e      = sb.pop_front();
            a_data = (e.inst == 0) ? rs0[e.port*32 +: 32] : rs1[e.port*32 +: 32];
            a_busy = (e.inst == 0) ? busy0[e.port] : busy1[e.port];
            a_any  = (e.inst == 0) ? any0 : any1;
            check($sformatf("%s dut%0d p%0d data", e.name, e.inst, e.port), a_data, e.data);
            check($sformatf("%s dut%0d p%0d busy", e.name, e.inst, e.port), 32'(a_busy), 32'(e.busy));
            check($sformatf("%s dut%0d p%0d any", e.name, e.inst, e.port), 32'(a_any), 32'(e.any));
        end
    end

    task automatic expect_port(input int inst, input int port, input logic [31:0] d,
                               input logic b, input logic a, input string name);
        exp_t e;
        e.inst = inst; e.port = port; e.data = d; e.busy = b; e.any = a; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_both(input int port, input logic [31:0] d, input logic b,
                               input logic a, input string name);
        expect_port(0, port, d, b, a, name);
        expect_port(1, port, d, b, a, name);
    endtask

    task automatic fire();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic iss(input logic en, input logic [4:0] a);
        issue_en = en; issue_addr = a;
    endtask

    task automatic wr0(input logic en, input logic [4:0] a, input logic [31:0] d);
        wr_en0 = en; rd_addr0 = a; rd0 = d;
    endtask

    task automatic wr1(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        wr_en1 = en; rd_addr1 = {a1, a0}; rd1 = {d1, d0};
    endtask

    task automatic idle();
        wr0(1'b0, 5'd0, 32'h0);
        wr1(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        iss(1'b0, 5'd0);
    endtask

    initial begin
        clk = 1'b0; clk_run = 1'b0; reset = 1'b1;
        idle();
        rd(5'd1, 5'd2);
        // Reset with no clock; a pending bypass write must not leak through.
        wr1(2'b01, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'h0);
        #25;
        expect_both(0, 32'h0, 1'b0, 1'b0, "reset");
        expect_both(1, 32'h0, 1'b0, 1'b0, "reset");
        fire();
        #23;
        idle();
        reset = 1'b0;
        clk_run = 1'b1;

        // Basic write/read and x0 drop.
        step();
        wr0(1'b1, 5'd1, 32'h1234_5678);
        wr1(2'b01, 5'd1, 5'd0, 32'h1234_5678, 32'h0);
        rd(5'd1, 5'd0);
        expect_port(0, 0, 32'h0, 1'b0, 1'b0, "wr_same_cycle");
        expect_port(1, 0, 32'h1234_5678, 1'b0, 1'b0, "wr_same_cycle");
        expect_both(1, 32'h0, 1'b0, 1'b0, "x0_read");
        fire();
        step();
        wr0(1'b1, 5'd0, 32'hDEAD_BEEF);
        wr1(2'b10, 5'd0, 5'd0, 32'h0, 32'hDEAD_BEEF);
        expect_both(0, 32'h1234_5678, 1'b0, 1'b0, "wr_next_cycle");
        expect_both(1, 32'h0, 1'b0, 1'b0, "x0_write_bypass");
        fire();
        step();
        idle();
        rd(5'd0, 5'd1);
        expect_both(0, 32'h0, 1'b0, 1'b0, "x0_after_write");
        expect_both(1, 32'h1234_5678, 1'b0, 1'b0, "x1_hold");
        fire();

        // Write-write collision with bypass.
        step();
        wr1(2'b11, 5'd7, 5'd7, 32'hAAAA_0000, 32'h5555_FFFF);
        rd(5'd7, 5'd7);
        expect_port(1, 0, 32'h5555_FFFF, 1'b0, 1'b0, "collide_bypass");
        expect_port(1, 1, 32'h5555_FFFF, 1'b0, 1'b0, "collide_bypass");
        fire();
        step();
        idle();
        rd(5'd7, 5'd0);
        expect_port(1, 0, 32'h5555_FFFF, 1'b0, 1'b0, "collide_stored");
        expect_port(0, 0, 32'h0, 1'b0, 1'b0, "x7_unwritten");
        fire();

        // Scoreboard set and clear.
        step();
        iss(1'b1, 5'd3);
        rd(5'd3, 5'd1);
        expect_both(0, 32'h0, 1'b0, 1'b0, "issue_same_cycle");
        fire();
        step();
        iss(1'b0, 5'd0);
        expect_both(0, 32'h0, 1'b1, 1'b1, "issue_busy");
        fire();
        step();
        wr0(1'b1, 5'd3, 32'h42);
        wr1(2'b01, 5'd3, 5'd0, 32'h42, 32'h0);
        expect_port(0, 0, 32'h0, 1'b1, 1'b1, "wb_same_cycle");
        expect_port(1, 0, 32'h42, 1'b0, 1'b1, "wb_same_cycle");
        fire();
        step();
        idle();
        expect_both(0, 32'h42, 1'b0, 1'b0, "wb_next_cycle");
        fire();

        // Issue and write collide: set wins.
        step();
        iss(1'b1, 5'd4);
        wr0(1'b1, 5'd4, 32'h11);
        wr1(2'b01, 5'd4, 5'd0, 32'h11, 32'h0);
        rd(5'd4, 5'd0);
        expect_port(0, 0, 32'h0, 1'b0, 1'b0, "iss_wr_same");
        expect_port(1, 0, 32'h11, 1'b1, 1'b0, "iss_wr_same");
        fire();
        step();
        idle();
        expect_both(0, 32'h11, 1'b1, 1'b1, "iss_wr_after");
        fire();
        step();
        wr0(1'b1, 5'd4, 32'h11);
        wr1(2'b01, 5'd4, 5'd0, 32'h11, 32'h0);
        expect_port(0, 0, 32'h11, 1'b1, 1'b1, "x4_clear_same");
        expect_port(1, 0, 32'h11, 1'b0, 1'b1, "x4_clear_same");
        fire();
        step();
        idle();
        iss(1'b1, 5'd0);
        rd(5'd0, 5'd4);
        expect_both(0, 32'h0, 1'b0, 1'b0, "issue_x0_same");
        expect_both(1, 32'h11, 1'b0, 1'b0, "x4_cleared");
        fire();
        step();
        iss(1'b0, 5'd0);
        expect_both(0, 32'h0, 1'b0, 1'b0, "issue_x0_after");
        fire();

        // Reset asserted between clock edges.
        step();
        wr0(1'b1, 5'd5, 32'hCAFE_F00D);
        wr1(2'b01, 5'd5, 5'd0, 32'hCAFE_F00D, 32'h0);
        iss(1'b1, 5'd6);
        rd(5'd5, 5'd6);
        step();
        idle();
        expect_both(0, 32'hCAFE_F00D, 1'b0, 1'b1, "pre_reset");
        expect_both(1, 32'h0, 1'b1, 1'b1, "pre_reset");
        fire();
        reset = 1'b1;
        wr1(2'b01, 5'd5, 5'd0, 32'h0000_1234, 32'h0);
        expect_both(0, 32'h0, 1'b0, 1'b0, "mid_reset");
        expect_both(1, 32'h0, 1'b0, 1'b0, "mid_reset");
        fire();
        step();
        idle();
        reset = 1'b0;
        step();
        expect_both(0, 32'h0, 1'b0, 1'b0, "post_reset");
        expect_both(1, 32'h0, 1'b0, 1'b0, "post_reset");
        fire();

        for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
        check("sb_drain", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
